// File: rtl/spi_frame_loader_if.sv
// Framebuffer write port driven by the SPI frame loader and consumed by the R/G/B RAMs.
interface spi_frame_loader_if #(
    parameter int N = 10
);
    logic         we;
    logic [N-1:0] wadr;
    logic         R_wd;
    logic         G_wd;
    logic         B_wd;

    modport master (output we, wadr, R_wd, G_wd, B_wd);
    modport slave  (input  we, wadr, R_wd, G_wd, B_wd);
endinterface

// File: rtl/spi_frame_loader.sv
// SPI (mode 0, MSB first) command decoder that loads or clears the LED-matrix framebuffer.
module spi_frame_loader #(
    parameter int         N         = 10,
    parameter logic [7:0] CMD_LOAD  = 8'hA5,
    parameter logic [7:0] CMD_CLEAR = 8'hC3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               spi_sck,
    input  logic               spi_cs_n,
    input  logic               spi_mosi,
    spi_frame_loader_if.master fb,
    output logic               busy,
    output logic               frame_done,
    output logic               frame_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_LOAD,
        S_PIX_A,
        S_PIX_B,
        S_DRAIN,
        S_CLEAR
    } state_e;

    localparam logic [N-1:0] ADR_LAST = '1;

    logic [2:0] sck_q;
    logic [2:0] cs_q;
    logic [1:0] mosi_q;
    logic       sck_rise;
    logic       cs_n_s;
    logic       cs_fall;
    logic       mosi_s;

    logic [2:0] bit_cnt_q;
    logic [7:0] shift_q;
    logic       byte_valid_q;

    state_e       state_q, state_d;
    logic [N-1:0] wadr_q, wadr_d;
    logic         we_q, we_d;
    logic [2:0]   rgb_q, rgb_d;
    logic [2:0]   pix_q, pix_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         err_q, err_d;

    // Idle values of the pins (sck low, cs_n high) so reset never fakes an edge.
    always_ff @(posedge clk) begin
        // NOTE: every clocked assignment is non-blocking so all flops sample pre-edge values.
        if (!rst_n) begin
            sck_q  <= 3'b000;
            cs_q   <= 3'b111;
            mosi_q <= 2'b00;
        end else begin
            sck_q  <= {sck_q[1:0], spi_sck};
            cs_q   <= {cs_q[1:0], spi_cs_n};
            mosi_q <= {mosi_q[0], spi_mosi};
        end
    end

    assign sck_rise = sck_q[1] & ~sck_q[2];
    assign cs_n_s   = cs_q[1];
    assign cs_fall  = cs_q[2] & ~cs_q[1];
    assign mosi_s   = mosi_q[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            byte_valid_q <= 1'b0;
        end else begin
            byte_valid_q <= 1'b0;
            if (cs_n_s) begin
                bit_cnt_q <= 3'd0;
            end else if (sck_rise) begin
                shift_q      <= {shift_q[6:0], mosi_s};
                bit_cnt_q    <= bit_cnt_q + 3'd1;
                byte_valid_q <= (bit_cnt_q == 3'd7);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wadr_q  <= '0;
            we_q    <= 1'b0;
            rgb_q   <= 3'b000;
            pix_q   <= 3'b000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wadr_q  <= wadr_d;
            we_q    <= we_d;
            rgb_q   <= rgb_d;
            pix_q   <= pix_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Outputs are registered: the write for a state is prepared on the transition into it.
    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch is inferred.
        state_d = state_q;
        wadr_d  = wadr_q;
        we_d    = 1'b0;
        rgb_d   = rgb_q;
        pix_d   = pix_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cs_fall) state_d = S_CMD;
            end
            S_CMD: begin
                if (byte_valid_q) begin
                    wadr_d = '0;
                    if (shift_q == CMD_LOAD) begin
                        state_d = S_LOAD;
                    end else if (shift_q == CMD_CLEAR) begin
                        state_d = S_CLEAR;
                        we_d    = 1'b1;
                        rgb_d   = 3'b000;
                    end else begin
                        state_d = S_DRAIN;
                        err_d   = 1'b1;
                    end
                end else if (cs_n_s) begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                // A byte completing together with cs_n rising still counts.
                if (byte_valid_q) begin
                    state_d = S_PIX_A;
                    we_d    = 1'b1;
                    rgb_d   = shift_q[6:4];
                    pix_d   = shift_q[2:0];
                end else if (cs_n_s) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end
            end
            S_PIX_A: begin
                state_d = S_PIX_B;
                we_d    = 1'b1;
                wadr_d  = wadr_q + 1'b1;
                rgb_d   = pix_q;
            end
            S_PIX_B: begin
                if (wadr_q == ADR_LAST) begin
                    state_d = S_DRAIN;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_LOAD;
                    wadr_d  = wadr_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (cs_n_s) state_d = S_IDLE;
            end
            S_CLEAR: begin
                if (wadr_q == ADR_LAST) begin
                    done_d  = 1'b1;
                    state_d = cs_n_s ? S_IDLE : S_DRAIN;
                end else begin
                    we_d   = 1'b1;
                    wadr_d = wadr_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_LOAD) || (state_d == S_PIX_A) ||
                 (state_d == S_PIX_B) || (state_d == S_CLEAR);
    end

    assign fb.we      = we_q;
    assign fb.wadr    = wadr_q;
    assign fb.R_wd    = rgb_q[2];
    assign fb.G_wd    = rgb_q[1];
    assign fb.B_wd    = rgb_q[0];
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;

endmodule

// File: tb/tb_spi_frame_loader.sv
// Self-checking bench: frame table, reset sequences and random frames scored against a write-list model.
`timescale 1ns/1ps
module tb_spi_frame_loader;

    localparam int N     = 10;
    localparam int NPIX  = 1 << N;
    localparam int CLK_P = 10;
    localparam int HALF  = 40;

    logic clk = 1'b0;
    logic rst_n;
    logic spi_sck;
    logic spi_cs_n;
    logic spi_mosi;
    logic busy;
    logic frame_done;
    logic frame_err;

    spi_frame_loader_if #(.N(N)) fb ();

    spi_frame_loader #(.N(N), .CMD_LOAD(8'hA5), .CMD_CLEAR(8'hC3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi_sck   (spi_sck),
        .spi_cs_n  (spi_cs_n),
        .spi_mosi  (spi_mosi),
        .fb        (fb),
        .busy      (busy),
        .frame_done(frame_done),
        .frame_err (frame_err)
    );

    always #(CLK_P / 2) clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: accumulates every write and pulse; the stimulus side takes snapshots.
    int unsigned  cyc       = 0;
    int           done_cnt  = 0;
    int           err_cnt   = 0;
    int           busy_viol = 0;
    logic [N-1:0] obs_adr[$];
    logic [2:0]   obs_rgb[$];
    int unsigned  obs_cyc[$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (fb.we === 1'b1) begin
            obs_adr.push_back(fb.wadr);
            obs_rgb.push_back({fb.R_wd, fb.G_wd, fb.B_wd});
            obs_cyc.push_back(cyc);
            if (busy !== 1'b1) busy_viol <= busy_viol + 1;
        end
        if (frame_done === 1'b1) done_cnt <= done_cnt + 1;
        if (frame_err === 1'b1) err_cnt <= err_cnt + 1;
    end

    // Reference model: the list of writes and pulses a frame must produce.
    logic [7:0]   tx_q[$];
    logic [N-1:0] exp_adr[$];
    logic [2:0]   exp_rgb[$];
    int           exp_done;
    int           exp_err;
    bit           exp_clear;

    task automatic build_expected();
        int         nd;
        int         nb;
        logic [7:0] b;
        exp_adr.delete();
        exp_rgb.delete();
        exp_done  = 0;
        exp_err   = 0;
        exp_clear = 1'b0;
        if (tx_q.size() == 0) return;
        if (tx_q[0] == 8'hA5) begin
            nd = tx_q.size() - 1;
            nb = (nd < NPIX / 2) ? nd : NPIX / 2;
            for (int k = 0; k < nb; k++) begin
                b = tx_q[k + 1];
                exp_adr.push_back(N'(2 * k));
                exp_rgb.push_back(b[6:4]);
                exp_adr.push_back(N'(2 * k + 1));
                exp_rgb.push_back(b[2:0]);
            end
            if (nd >= NPIX / 2) exp_done = 1;
            else exp_err = 1;
        end else if (tx_q[0] == 8'hC3) begin
            exp_clear = 1'b1;
            for (int a = 0; a < NPIX; a++) begin
                exp_adr.push_back(N'(a));
                exp_rgb.push_back(3'b000);
            end
            exp_done = 1;
        end else begin
            exp_err = 1;
        end
    endtask

    task automatic spi_byte(input logic [7:0] b, input bit early_cs);
        for (int i = 7; i >= 0; i--) begin
            spi_mosi = b[i];
            #(HALF);
            spi_sck = 1'b1;
            if (early_cs && i == 0) begin
                #(CLK_P);
                spi_cs_n = 1'b1;
                #(HALF - CLK_P);
            end else begin
                #(HALF);
            end
            spi_sck = 1'b0;
        end
    endtask

    // SPI edges land 3 ns before a clk rising edge, never on it.
    task automatic send_frame(input bit early_cs);
        @(negedge clk);
        #2;
        spi_cs_n = 1'b0;
        #(HALF);
        foreach (tx_q[i]) spi_byte(tx_q[i], early_cs && (i == tx_q.size() - 1));
        #(HALF);
        spi_cs_n = 1'b1;
        #(8 * HALF);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({name, ":idle_timeout"}, (n >= 3000), 0);
        repeat (8) @(negedge clk);
    endtask

    task automatic compare_writes(input string name, input int base, input int nwr);
        int lim;
        int gap_bad = 0;
        lim = (nwr < exp_adr.size()) ? nwr : exp_adr.size();
        for (int i = 0; i < lim; i++)
            check($sformatf("%s:wr%0d", name, i),
                  {obs_adr[base + i], obs_rgb[base + i]}, {exp_adr[i], exp_rgb[i]});
        for (int i = 1; i < nwr; i++)
            if ((exp_clear || (i % 2 == 1)) && (obs_cyc[base + i] - obs_cyc[base + i - 1] != 1))
                gap_bad++;
        check({name, ":write_gaps"}, gap_bad, 0);
    endtask

    task automatic run_frame(input string name, input bit early,
                             output int nwr, output int ndone, output int nerr);
        int b_wr, b_done, b_err, b_viol;
        build_expected();
        b_wr   = obs_adr.size();
        b_done = done_cnt;
        b_err  = err_cnt;
        b_viol = busy_viol;
        send_frame(early);
        wait_idle(name);
        nwr   = obs_adr.size() - b_wr;
        ndone = done_cnt - b_done;
        nerr  = err_cnt - b_err;
        compare_writes(name, b_wr, nwr);
        check({name, ":we_without_busy"}, busy_viol - b_viol, 0);
    endtask

    typedef struct {
        logic [7:0] cmd;
        bit         has_cmd;
        int         nbytes;
        logic [7:0] data;
        bit         early_cs;
        int         exp_wr;
        int         exp_done;
        int         exp_err;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nwr, ndone, nerr;
        int b_wr, b_done, b_err;
        int n;
        string nm;

        vecs[0] = '{8'hA5, 1'b1, 10,  8'h77, 1'b0, 20,   0, 1};  // aborted load
        vecs[1] = '{8'hA5, 1'b1, 3,   8'h5A, 1'b0, 6,    0, 1};  // restarts at 0
        vecs[2] = '{8'h3C, 1'b1, 4,   8'hFF, 1'b0, 0,    0, 1};  // bad command
        vecs[3] = '{8'h00, 1'b0, 0,   8'h00, 1'b0, 0,    0, 0};  // cs pulse, no byte
        vecs[4] = '{8'hA5, 1'b1, 0,   8'h00, 1'b0, 0,    0, 1};  // load, no data
        vecs[5] = '{8'hC3, 1'b1, 0,   8'h00, 1'b0, NPIX, 1, 0};  // clear, cs up at once
        vecs[6] = '{8'hC3, 1'b1, 3,   8'hA5, 1'b0, NPIX, 1, 0};  // bytes during clear
        vecs[7] = '{8'hA5, 1'b1, 2,   8'h2D, 1'b1, 4,    0, 1};  // cs rise with last byte
        vecs[8] = '{8'hA5, 1'b1, 513, 8'h61, 1'b0, NPIX, 1, 0};  // full load + extra byte

        // Reset with random pins.
        rst_n    = 1'b0;
        spi_sck  = 1'($urandom);
        spi_cs_n = 1'($urandom);
        spi_mosi = 1'($urandom);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst:we", fb.we, 0);
            check("rst:wadr", fb.wadr, 0);
            check("rst:rgb", {fb.R_wd, fb.G_wd, fb.B_wd}, 0);
            check("rst:busy", busy, 0);
            check("rst:done", frame_done, 0);
            check("rst:err", frame_err, 0);
            spi_sck  = 1'($urandom);
            spi_cs_n = 1'($urandom);
            spi_mosi = 1'($urandom);
        end
        spi_sck  = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        b_wr   = obs_adr.size();
        b_done = done_cnt;
        b_err  = err_cnt;
        repeat (20) @(negedge clk);
        check("idle:nwr", obs_adr.size() - b_wr, 0);
        check("idle:busy", busy, 0);
        check("idle:done", done_cnt - b_done, 0);
        check("idle:err", err_cnt - b_err, 0);

        // Table of frames.
        for (int i = 0; i < 9; i++) begin
            tx_q.delete();
            if (vecs[i].has_cmd) tx_q.push_back(vecs[i].cmd);
            for (int k = 0; k < vecs[i].nbytes; k++) tx_q.push_back(vecs[i].data);
            nm = $sformatf("vec%0d", i);
            run_frame(nm, vecs[i].early_cs, nwr, ndone, nerr);
            check({nm, ":nwr"}, nwr, vecs[i].exp_wr);
            check({nm, ":done"}, ndone, vecs[i].exp_done);
            check({nm, ":err"}, nerr, vecs[i].exp_err);
        end

        // Reset in the middle of a load, right after byte 100 has been written.
        tx_q.delete();
        tx_q.push_back(8'hA5);
        for (int k = 0; k < 104; k++) tx_q.push_back(8'($urandom));
        build_expected();
        b_wr = obs_adr.size();
        n    = 0;
        fork
            send_frame(1'b0);
            begin
                while ((obs_adr.size() - b_wr) < 200 && n < 20000) begin
                    @(negedge clk);
                    #1;
                    n++;
                end
                check("rstmid:reach_byte100", (n < 20000), 1);
                rst_n = 1'b0;
                repeat (3) @(negedge clk);
                check("rstmid:nwr", obs_adr.size() - b_wr, 200);
                check("rstmid:we", fb.we, 0);
                check("rstmid:busy", busy, 0);
            end
        join
        compare_writes("rstmid", b_wr, 200);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("rstmid:quiet_after_release", obs_adr.size() - b_wr, 200);

        tx_q.delete();
        tx_q.push_back(8'hA5);
        for (int k = 0; k < 5; k++) tx_q.push_back(8'($urandom));
        run_frame("post_rst", 1'b0, nwr, ndone, nerr);
        check("post_rst:nwr", nwr, exp_adr.size());
        check("post_rst:done", ndone, exp_done);
        check("post_rst:err", nerr, exp_err);

        // Random frames against the model.
        for (int f = 0; f < 6; f++) begin
            int         kind;
            logic [7:0] c;
            kind = $urandom_range(0, 3);
            tx_q.delete();
            case (kind)
                0: begin
                    tx_q.push_back(8'hA5);
                    repeat ($urandom_range(0, 12)) tx_q.push_back(8'($urandom));
                end
                1: begin
                    c = 8'($urandom);
                    while (c == 8'hA5 || c == 8'hC3) c = 8'($urandom);
                    tx_q.push_back(c);
                    repeat ($urandom_range(0, 3)) tx_q.push_back(8'($urandom));
                end
                2: ;
                default: begin
                    tx_q.push_back(8'hC3);
                    repeat ($urandom_range(0, 2)) tx_q.push_back(8'($urandom));
                end
            endcase
            nm = $sformatf("rnd%0d", f);
            run_frame(nm, 1'($urandom), nwr, ndone, nerr);
            check({nm, ":nwr"}, nwr, exp_adr.size());
            check({nm, ":done"}, ndone, exp_done);
            check({nm, ":err"}, nerr, exp_err);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_frame_loader.md
Name: spi_frame_loader

Overview:
- Host-side writer for the LED-matrix framebuffer: receives pixel data from the host microcontroller over SPI (mode 0, MSB first) and drives the write port of the R/G/B framebuffer RAMs read by the matrix scan driver.
- Decodes a one-byte command per chip-select frame. It either streams 512 data bytes (two pixels per byte) into addresses 0..1023 or clears the whole buffer.
- Sits between the SPI pins and the RAM write-enable/address/data inputs.

Parameters:
- N, 10, framebuffer address width; pixel count = 2**N.
- CMD_LOAD, 8'hA5, command byte: load full frame from address 0.
- CMD_CLEAR, 8'hC3, command byte: write 0 to every address.

Ports:
- clk  in  1  system clock (same clock as the scan driver and RAMs).
- rst_n  in  1  synchronous active-low reset.
- spi_sck  in  1  SPI clock, asynchronous to clk; idles low.
- spi_cs_n  in  1  SPI chip select, active low, asynchronous.
- spi_mosi  in  1  SPI data, asynchronous.
- we  out  1  framebuffer write enable, one-cycle pulses.
- wadr  out  N  framebuffer write address.
- R_wd, G_wd, B_wd  out  1 each  pixel colour bits written when we=1.
- busy  out  1  high while in CLEAR or LOAD/PIX states.
- frame_done  out  1  one-cycle pulse after the last pixel of a load or clear is written.
- frame_err  out  1  one-cycle pulse on aborted or malformed frame.

Behaviour:
- Reset is synchronous. With rst_n=0 at posedge clk, all registers clear: state=IDLE, we=0, wadr=0, R/G/B_wd=0, busy=0, frame_done=0, frame_err=0, and the bit counter and shift register are 0. Reset mid-frame abandons the frame with no further writes.
- Input sync: spi_sck, spi_cs_n and spi_mosi each pass through 2 flops. A third sck flop provides rising-edge detect. Synchronizer flops reset to sck=0, cs_n=1, mosi=0.
- Requirement: clk ≥ 8× SCK frequency. Sync latency is 2–3 clk.
- Bit capture: on a detected sck rise with synced cs_n=0, shift in mosi at the LSB. A 3-bit counter increments per bit; count 7→0 completes a byte and raises an internal byte_valid for 1 clk. Synced cs_n=1 forces the bit counter to 0.
- Byte format in LOAD: bits [6:4] = {R,G,B} of pixel 2k; bits [2:0] = {R,G,B} of pixel 2k+1; bits 7 and 3 are ignored.
- FSM states: IDLE, CMD, LOAD, PIX_A, PIX_B, DRAIN, CLEAR.
  - IDLE: cs_n falling (synced) → CMD.
  - CMD: on byte_valid:
    - CMD_LOAD → LOAD with wadr=0.
    - CMD_CLEAR → CLEAR with wadr=0.
    - Any other byte → DRAIN with a frame_err pulse.
    - cs_n rising before byte_valid → IDLE, no error.
  - LOAD: byte_valid latches the byte → PIX_A.
  - PIX_A: we=1, wadr=current address, data=byte[6:4]. Address increments → PIX_B.
  - PIX_B: we=1, data=byte[2:0], address increments. If the address just written was 2**N−1, pulse frame_done → DRAIN; otherwise → LOAD.
  - Each byte therefore produces exactly 2 consecutive write cycles, starting the cycle after byte_valid.
  - LOAD with cs_n rising before 512 bytes → IDLE with a frame_err pulse. Pixels already written stay.
  - DRAIN: ignore all bytes until cs_n rises → IDLE. Extra bytes after a complete load do not set frame_err.
  - CLEAR: we=1 every cycle with R/G/B_wd=0 and wadr incrementing 0..2**N−1 (2**N cycles). After the last address, pulse frame_done, then → DRAIN if cs_n=0, else → IDLE.
  - CLEAR runs to completion regardless of cs_n. Bytes received during CLEAR are discarded.
- Address arithmetic is N-bit, and wrap never occurs within a frame because the FSM leaves on the last address.
- busy=1 in LOAD, PIX_A, PIX_B and CLEAR.
- we=0 in all states except PIX_A, PIX_B and CLEAR. R/G/B_wd hold their last value when we=0.
- Simultaneous cs_n rise and final byte_valid: the byte counts; writes complete, then → IDLE.
- No read-back: the scan driver's reads on the other RAM port are unaffected. Tearing during a load is accepted.

Test Plan:
- Reset: rst_n=0 for 2 clk with random SPI pins → we=0, wadr=0, busy=0, no pulses. Release with cs_n=1 → state IDLE, no writes.
- Full load: send 0xA5, then 512 bytes of 0x61 → 1024 writes with {R,G,B}=110 at even addresses and 001 at odd; wadr runs 0..1023 in order; exactly one frame_done after the write to 1023; frame_err=0.
- Clear: send 0xC3 and raise cs_n immediately → 1024 consecutive we cycles with data 0 and wadr 0..1023; busy high throughout; one frame_done.
- Bad command: send 0x3C, then 4 bytes → exactly one frame_err pulse, zero writes, and return to IDLE on cs_n rise.
- Aborted load: send 0xA5 plus 10 bytes 0x77, then cs_n high → exactly 20 writes (addresses 0..19, data 111); one frame_err; no frame_done. A following 0xA5 load restarts at wadr=0.
- Reset mid-load: assert rst_n=0 after byte 100 of a load → writes stop within 1 clk; after release, a fresh 0xA5 frame writes starting at address 0.
